// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: {bout, diff} = a - b - bin, LSB first, one bit
// per clock through a single full-subtractor cell, with a start/busy/done handshake.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic d_bit;
  logic br_next;
  logic accept;
  logic last;

  // Full-subtractor cell working on the current LSBs of the operand shift registers.
  assign d_bit   = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  // A new request is taken in IDLE and in the DONE cycle, never mid-operation.
  assign accept = start && (state_q != SHIFT);
  assign last   = (state_q == SHIFT) && (cnt == CW'(WIDTH - 1));

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      br   <= bin;
      cnt  <= '0;
    end else if (state_q == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      res  <= {d_bit, res[WIDTH-1:1]};
      br   <= br_next;
      cnt  <= cnt + CW'(1);
      // The final difference bit goes straight into diff alongside the shifted result.
      if (last) begin
        diff <= {d_bit, res[WIDTH-1:1]};
        bout <= br_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed table, handshake corner cases,
// exhaustive WIDTH=4 sweep and randomized ops against an arithmetic model.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer subtraction, borrow is the sign of the true result.
  function automatic logic [W:0] ref_sub(input int ra, input int rb, input int rbin);
    int t;
    t = ra - rb - rbin;
    ref_sub = {logic'(t < 0), W'(t & ((1 << W) - 1))};
  endfunction

  // Launch an op at a negedge (start high for one edge), then wait for done.
  // lat counts edges after the accepting edge; bcnt counts samples with busy=1.
  // With noisy set, stray start pulses and operand changes are driven while busy.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input bit noisy, output int lat, output int bcnt);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      if (noisy) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom); start = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
  endtask

  vec_t vecs[6];

  initial begin
    int lat, bcnt;
    logic [W:0] exp;
    logic [W-1:0] held;
    bit saw_done;
    int sum;

    vecs[0] = '{a: 4'd6,  b: 4'd2,  bin: 1'b0, exp_diff: 4'd4,  exp_bout: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd5,  bin: 1'b0, exp_diff: 4'd14, exp_bout: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, exp_diff: 4'd15, exp_bout: 1'b1};
    vecs[3] = '{a: 4'd15, b: 4'd15, bin: 1'b0, exp_diff: 4'd0,  exp_bout: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd15, bin: 1'b1, exp_diff: 4'd15, exp_bout: 1'b1};
    vecs[5] = '{a: 4'd7,  b: 4'd3,  bin: 1'b1, exp_diff: 4'd3,  exp_bout: 1'b0};

    rst = 1'b1; start = 1'b1; a = '1; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_bout", bout, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, lat, bcnt);
      check($sformatf("tbl%0d_latency", i), lat, W);
      check($sformatf("tbl%0d_busy_cycles", i), bcnt, W);
      check($sformatf("tbl%0d_busy_at_done", i), busy, 0);
      check($sformatf("tbl%0d_diff", i), diff, vecs[i].exp_diff);
      check($sformatf("tbl%0d_bout", i), bout, vecs[i].exp_bout);
      @(negedge clk);
      check($sformatf("tbl%0d_done_low", i), done, 0);
      check($sformatf("tbl%0d_diff_hold", i), diff, vecs[i].exp_diff);
    end

    // Start while busy is ignored; back-to-back start in the DONE cycle is accepted
    a = 4'd13; b = 4'd6; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 4'd9; b = 4'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'd0; b = 4'd0;
    check("ignore_diff_held", diff, vecs[5].exp_diff);
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ignore_latency", lat, W);
    check("ignore_diff", diff, 7);
    check("ignore_bout", bout, 0);
    run_op(4'd10, 4'd4, 1'b0, 1'b0, lat, bcnt);
    check("b2b_latency", lat, W);
    check("b2b_diff", diff, 6);
    check("b2b_bout", bout, 0);
    @(negedge clk);

    // Reset two cycles into an operation aborts it
    a = 4'd2; b = 4'd9; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    saw_done = 1'b0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_activity", saw_done, 0);
    run_op(4'd11, 4'd4, 1'b1, 1'b0, lat, bcnt);
    check("post_abort_latency", lat, W);
    check("post_abort_diff", diff, 6);
    check("post_abort_bout", bout, 0);

    // Exhaustive sweep, back-to-back in the DONE cycle, checked by the adder identity
    for (int x = 0; x < (1 << (2 * W + 1)); x++) begin
      logic [W-1:0] sa, sb;
      logic sbin;
      sa = W'(x >> (W + 1));
      sb = W'(x >> 1);
      sbin = 1'(x);
      run_op(sa, sb, sbin, 1'b0, lat, bcnt);
      sum = int'(diff) + int'(sb) + int'(sbin);
      check($sformatf("sweep_%0d_%0d_%0d_latency", sa, sb, sbin), lat, W);
      check($sformatf("sweep_%0d_%0d_%0d_sum", sa, sb, sbin), sum & ((1 << W) - 1), sa);
      check($sformatf("sweep_%0d_%0d_%0d_carry", sa, sb, sbin), (sum >> W) & 1, bout);
    end
    @(negedge clk);

    // Randomized ops with noise on the inputs while busy
    for (int n = 0; n < 200; n++) begin
      logic [W-1:0] ra, rb;
      logic rbin;
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      exp = ref_sub(ra, rb, rbin);
      run_op(ra, rb, rbin, 1'b1, lat, bcnt);
      check($sformatf("rand%0d_latency", n), lat, W);
      check($sformatf("rand%0d_result", n), {bout, diff}, exp);
      held = diff;
      if ($urandom_range(1, 0) == 0) begin
        @(negedge clk);
        check($sformatf("rand%0d_done_low", n), done, 0);
        check($sformatf("rand%0d_hold", n), diff, held);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
